// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter/sequencer for a shared 2^N:1 datapath mux.
// Holds a grant until done, owner withdrawal, or watchdog expiry; one idle cycle between grants.
module rr_mux_arbiter #(
  parameter int N   = 2,
  parameter int TMO = 16,
  parameter int CW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2**N-1:0] req,
  input  logic            done,
  output logic [N-1:0]    sel,
  output logic [2**N-1:0] gnt,
  output logic            gnt_valid,
  output logic            tmo,
  output logic [N-1:0]    tmo_id
);
  localparam int NR = 2**N;
  localparam logic [NR-1:0] ONE = NR'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sel_q, sel_d, last_q, last_d, tmo_id_q, tmo_id_d;
  logic [NR-1:0] gnt_q, gnt_d;
  logic          vld_q, vld_d, tmo_q, tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  win, idx;
  logic          found, wd_hit;

  // Search last+1 .. last+NR; N-bit addition wraps modulo NR for free.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      idx = last_q + k[N-1:0];
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign wd_hit = (TMO != 0) && (cnt_q == CW'(TMO - 1));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    vld_d    = vld_q;
    tmo_d    = 1'b0;
    tmo_id_d = tmo_id_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          sel_d   = win;
          gnt_d   = ONE << win;
          vld_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (done || !req[sel_q] || wd_hit) begin
          state_d = IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          last_d  = sel_q;
          // done and withdrawal both outrank the watchdog
          if (!done && req[sel_q] && wd_hit) begin
            tmo_d    = 1'b1;
            tmo_id_d = sel_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      gnt_q    <= '0;
      vld_q    <= 1'b0;
      tmo_q    <= 1'b0;
      tmo_id_q <= '0;
      cnt_q    <= '0;
      last_q   <= '1;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      vld_q    <= vld_d;
      tmo_q    <= tmo_d;
      tmo_id_q <= tmo_id_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign gnt_valid = vld_q;
  assign tmo       = tmo_q;
  assign tmo_id    = tmo_id_q;

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 2^N:1 L-bit datapath mux in the multicycle 16-bit RISC-V core.
- Example shared resource: the memory/ALU operand bus.
- Grants the mux to one of 2^N requesters at a time and drives the mux select.
- Holds the grant until the resource signals completion, the owner withdraws, or a watchdog expires.

Parameters:
- N, 2, number of select bits; 2^N requesters.
- TMO, 16, watchdog limit in cycles of one grant; 0 disables the watchdog.
- CW, 5, width of the watchdog counter; must satisfy 2^CW > TMO.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  2^N  level request per requester; bit i = requester i.
- done  in  1  resource completion strobe for the current owner, one cycle.
- sel  out  N  mux select; index of the current owner.
- gnt  out  2^N  one-hot grant; all zero when no owner.
- gnt_valid  out  1  high while a grant is held.
- tmo  out  1  one-cycle pulse when the watchdog aborts a grant.
- tmo_id  out  N  index of the last requester aborted by the watchdog.

Behaviour:
- All outputs are registered.
- Reset values (rst high at any clock edge, including mid-grant):
  - state = IDLE; sel = 0; gnt = 0; gnt_valid = 0; tmo = 0; tmo_id = 0.
  - watchdog counter = 0; internal last-owner pointer = 2^N-1, so requester 0 has top priority after reset.
- rst overrides all other inputs in the same edge.
- States: IDLE, BUSY.
- IDLE:
  - If req != 0, choose the first set bit searching last+1, last+2, ... modulo 2^N (wraps past 2^N-1 to 0).
  - Next edge: sel = winner, gnt = one-hot(winner), gnt_valid = 1, counter = 0, state = BUSY.
  - Latency: req seen at edge t -> gnt_valid high after edge t.
  - If req == 0, stay IDLE with outputs unchanged (gnt_valid = 0, sel retains its last value).
  - done is ignored in IDLE.
- BUSY:
  - sel and gnt are held stable; the counter increments every cycle.
  - Release conditions, evaluated in priority order:
    - done = 1 -> normal release.
    - req[sel] = 0 -> owner withdrew; release without done.
    - TMO != 0 and counter == TMO-1 -> watchdog release; tmo = 1 for exactly one cycle and tmo_id = sel, both at the same edge as the release.
  - On any release at an edge:
    - gnt = 0, gnt_valid = 0, last = sel, state = IDLE; sel keeps its value.
  - done and watchdog in the same cycle: done wins, no tmo pulse.
- Turnaround: after any release, at least one IDLE cycle with gnt_valid = 0 precedes the next grant. There are no back-to-back grants, so the bus is guaranteed one idle cycle.
- Fairness:
  - The pointer updates only on release, so a requester that stays asserted waits at most 2^N-1 grants.
  - The releasing owner has the lowest priority in the next arbitration.
- Other inputs:
  - Requests arriving or changing during BUSY do not affect the current grant, except req[sel] falling.
  - req bits are sampled only at IDLE edges and at release checks.
- Invariants (for assertions):
  - gnt has at most one bit set.
  - gnt != 0 iff gnt_valid.
  - When gnt_valid = 1, gnt == one-hot(sel).
  - tmo is never high for two consecutive cycles.

Test Plan:
- Reset mid-grant:
  - Stimulus: N=2; grant requester 2, then assert rst for 1 cycle.
  - Required response: next cycle gnt = 0000, gnt_valid = 0, tmo = 0.
  - Then req = 1111 -> requester 0 granted (sel = 0) one cycle after the request.
- Round-robin wrap:
  - Stimulus: req = 1111 held; done pulsed 2 cycles after each grant.
  - Required response: grant order 0, 1, 2, 3, 0.
  - Each grant is separated by exactly one cycle with gnt_valid = 0.
- Single requester:
  - Stimulus: req = 0100 only, with done after 3 cycles.
  - Required response: sel = 2 and gnt = 0100 one cycle after the request.
  - Release the cycle after done; regranted to 2 after one idle cycle.
- Watchdog timeout:
  - Stimulus: TMO = 4; req = 0010, done never asserted.
  - Required response: tmo pulses once with tmo_id = 1 at the 4th cycle of the grant, and gnt_valid drops at the same edge.
  - Then with done pulsed on the watchdog's final cycle (counter == 3): no tmo pulse, normal release.
- Owner withdrawal and stray done:
  - Stimulus: requester 3 granted, then req[3] drops with no done.
  - Required response: release next edge, last = 3, so the next order starts at 0.
  - done pulsed in IDLE causes no state change.
